// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel period/duty/mode with a shared prescaler tick.
// Host writes land in shadow registers and reach the active set only at a period boundary.
module led_pattern_gen #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRESCALE   = 1,
  parameter int DEF_PERIOD = 100000,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] wrap,
  output logic [NUM_CH-1:0] done
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_PERIOD / 2);

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_PWM     = 3'd3,
    MODE_ONESHOT = 3'd4
  } mode_e;

  // Unused codes 5-7 collapse to OFF so the active set only ever holds legal modes.
  function automatic mode_e decode_mode(input logic [2:0] code);
    case (code)
      3'd1:    return MODE_ON;
      3'd2:    return MODE_BLINK;
      3'd3:    return MODE_PWM;
      3'd4:    return MODE_ONESHOT;
      default: return MODE_OFF;
    endcase
  endfunction

  logic [PS_W-1:0] presc;
  logic            tick;
  logic            cfg_fire;

  assign tick     = (presc == PS_W'(PRESCALE - 1));
  assign cfg_fire = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] sh_period;
    logic [CNT_W-1:0] sh_duty;
    logic [2:0]       sh_mode;
    logic [CNT_W-1:0] act_period;
    logic [CNT_W-1:0] act_duty;
    mode_e            act_mode;
    logic [CNT_W-1:0] cnt;
    logic             led_q;
    logic             wrap_q;
    logic             done_q;
    logic             wr_hit;
    logic             wr_mode;
    logic             running;
    logic             at_end;
    logic             wrap_now;
    logic             oneshot_end;
    logic             led_next;

    assign wr_hit      = cfg_fire && (cfg_ch == CH_W'(g));
    assign wr_mode     = wr_hit && (cfg_sel == 2'd2);
    assign running     = (act_mode != MODE_OFF);
    // Period 0 and 1 both mean "wrap on every tick".
    assign at_end      = (act_period <= CNT_W'(1)) || (cnt >= act_period - CNT_W'(1));
    assign wrap_now    = running && tick && at_end;
    assign oneshot_end = wrap_now && (act_mode == MODE_ONESHOT);

    always_comb begin
      led_next = 1'b0;
      case (act_mode)
        MODE_ON:                led_next = 1'b1;
        MODE_BLINK:             led_next = (cnt < (act_period >> 1));
        MODE_PWM, MODE_ONESHOT: led_next = (cnt < act_duty);
        default:                led_next = 1'b0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        sh_period  <= DEF_P;
        sh_duty    <= DEF_D;
        sh_mode    <= 3'd0;
        act_period <= DEF_P;
        act_duty   <= DEF_D;
        act_mode   <= MODE_OFF;
        cnt        <= '0;
        led_q      <= 1'b0;
        wrap_q     <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        if (!running) begin
          cnt <= '0;
        end else if (tick) begin
          cnt <= at_end ? '0 : cnt + CNT_W'(1);
        end

        // Transfer reads the pre-edge shadow, so a same-edge write waits for the next boundary.
        if (!running || wrap_now) begin
          act_period <= sh_period;
          act_duty   <= sh_duty;
          act_mode   <= decode_mode(sh_mode);
        end
        if (oneshot_end) begin
          act_mode <= MODE_OFF;
          if (!wr_mode) begin
            sh_mode <= 3'd0;
          end
        end

        if (wr_hit) begin
          case (cfg_sel)
            2'd0:    sh_period <= cfg_data;
            2'd1:    sh_duty   <= cfg_data;
            2'd2:    sh_mode   <= cfg_data[2:0];
            default: ;
          endcase
        end

        led_q  <= led_next;
        wrap_q <= wrap_now;
        done_q <= oneshot_end;
      end
    end

    assign led[g]  = led_q;
    assign wrap[g] = wrap_q;
    assign done[g] = done_q;
  end

endmodule
